// File: rtl/ds_bypass_unit_pkg.sv
// Shared decode-stage constants: MIPS opcode/funct encodings and the
// layout of one forwarding slot {valid, ready, addr[4:0], data[31:0]}.
package ds_bypass_unit_pkg;

  localparam int FWD_W       = 39;
  localparam int FWD_VALID   = 38;
  localparam int FWD_READY   = 37;
  localparam int FWD_ADDR_HI = 36;
  localparam int FWD_ADDR_LO = 32;
  localparam int FWD_DATA_HI = 31;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

endpackage

// File: rtl/ds_bypass_unit_src_use_decode.sv
// Source-register usage decode: tells the bypass logic whether the
// instruction in decode actually reads rs and/or rt, so that unused
// fields never cause a false forward or a false interlock.
module ds_src_use_decode (
  input  logic [31:0] inst,
  output logic        rs_used,
  output logic        rt_used
);
  import ds_bypass_unit_pkg::*;

  logic [5:0] op;
  logic [5:0] fn;
  logic       special;
  logic       r_alu;
  logic       r_shift_var;
  logic       r_shift_imm;
  logic       r_muldiv;
  logic       r_move_to;
  logic       r_jump_reg;
  logic       i_alu;
  logic       branch;
  logic       unused_fields;

  assign op      = inst[31:26];
  assign fn      = inst[5:0];
  assign special = (op == OP_SPECIAL);

  // Register fields and immediates carry no usage information.
  assign unused_fields = ^inst[25:6];

  // Classify the instruction into the groups that read rs/rt.
  always_comb begin
    r_alu       = special && (fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
                                         FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU});
    r_shift_var = special && (fn inside {FN_SLLV, FN_SRLV, FN_SRAV});
    r_shift_imm = special && (fn inside {FN_SLL, FN_SRL, FN_SRA});
    r_muldiv    = special && (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    r_move_to   = special && (fn inside {FN_MTHI, FN_MTLO});
    r_jump_reg  = special && (fn inside {FN_JR, FN_JALR});
    i_alu       = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
    branch      = op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM};
    rs_used     = r_alu || r_shift_var || r_muldiv || r_move_to || r_jump_reg ||
                  i_alu || (op == OP_LW) || (op == OP_SW) || branch;
    // Variable shifts shift the rt value by rs, so both are read.
    rt_used     = r_alu || r_shift_var || r_shift_imm || r_muldiv ||
                  (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  end

endmodule

// File: rtl/ds_bypass_unit.sv
// Decode-stage front end: fetch-to-decode register with valid/allowin
// handshake, rs/rt operand bypass from NUM_FWD prioritised producers
// (slot 0 youngest) and the load-use / not-ready interlock.
// Optional build macro DS_PERF_CNT_EN adds the saturating stall_cnt port.
module ds_bypass_unit #(
  parameter int NUM_FWD = 3,
  parameter int FWD_W   = ds_bypass_unit_pkg::FWD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fs_to_ds_valid,
  input  logic [31:0]              fs_inst,
  input  logic [31:0]              fs_pc,
  output logic                     ds_allowin,
  input  logic                     es_allowin,
  input  logic                     flush,
  input  logic [NUM_FWD*FWD_W-1:0] fwd_bus,
  output logic [4:0]               rf_raddr1,
  output logic [4:0]               rf_raddr2,
  input  logic [31:0]              rf_rdata1,
  input  logic [31:0]              rf_rdata2,
  output logic                     ds_to_es_valid,
  output logic [31:0]              ds_inst,
  output logic [31:0]              ds_pc,
  output logic [31:0]              rs_value,
  output logic [31:0]              rt_value,
  output logic                     ds_stall
`ifdef DS_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);
  import ds_bypass_unit_pkg::*;

  logic             ds_valid;
  logic             ds_ready_go;
  logic             rs_used;
  logic             rt_used;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rs_hit;
  logic             rs_rdy;
  logic             rt_hit;
  logic             rt_rdy;
  logic [FWD_W-1:0] slot;

  ds_src_use_decode u_src_use (
    .inst    (ds_inst),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  assign rs        = ds_inst[25:21];
  assign rt        = ds_inst[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  assign ds_stall       = ds_valid && ((rs_hit && !rs_rdy) || (rt_hit && !rt_rdy));
  assign ds_ready_go    = !ds_stall;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;

  // Fetch-to-decode register; flush wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_inst  <= 32'd0;
      ds_pc    <= 32'd0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        ds_inst <= fs_inst;
        ds_pc   <= fs_pc;
      end
    end
  end

  // Operand resolution: scan oldest to youngest so the youngest match is
  // the last one written and therefore wins, ready or not.
  always_comb begin
    rs_hit   = 1'b0;
    rs_rdy   = 1'b0;
    rt_hit   = 1'b0;
    rt_rdy   = 1'b0;
    rs_value = rf_rdata1;
    rt_value = rf_rdata2;
    slot     = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      slot = fwd_bus[k*FWD_W +: FWD_W];
      if (slot[FWD_VALID] && rs_used && (rs != 5'd0) &&
          (slot[FWD_ADDR_HI:FWD_ADDR_LO] == rs)) begin
        rs_hit   = 1'b1;
        rs_rdy   = slot[FWD_READY];
        rs_value = slot[FWD_DATA_HI:0];
      end
      if (slot[FWD_VALID] && rt_used && (rt != 5'd0) &&
          (slot[FWD_ADDR_HI:FWD_ADDR_LO] == rt)) begin
        rt_hit   = 1'b1;
        rt_rdy   = slot[FWD_READY];
        rt_value = slot[FWD_DATA_HI:0];
      end
    end
  end

`ifdef DS_PERF_CNT_EN
  // Saturating count of interlock cycles, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (ds_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ds_bypass_unit.sv
// Self-checking bench for ds_bypass_unit: directed scenarios followed by a
// randomized run against a behavioural model of the decode stage.
module tb_ds_bypass_unit;

  localparam int NUM_FWD = 3;
  localparam int FWD_W   = 39;
  localparam int NK      = 30;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     fs_to_ds_valid;
  logic [31:0]              fs_inst;
  logic [31:0]              fs_pc;
  logic                     ds_allowin;
  logic                     es_allowin;
  logic                     flush;
  logic [NUM_FWD*FWD_W-1:0] fwd_bus;
  logic [4:0]               rf_raddr1;
  logic [4:0]               rf_raddr2;
  logic [31:0]              rf_rdata1;
  logic [31:0]              rf_rdata2;
  logic                     ds_to_es_valid;
  logic [31:0]              ds_inst;
  logic [31:0]              ds_pc;
  logic [31:0]              rs_value;
  logic [31:0]              rt_value;
  logic                     ds_stall;
`ifdef DS_PERF_CNT_EN
  logic [31:0]              stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Instruction kinds with the architectural rs/rt read behaviour.
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rtf;
    bit         rs_u;
    bit         rt_u;
  } kind_t;

  kind_t kinds [0:NK-1] = '{
    '{6'h00, 6'h21, 5'd0, 1'b1, 1'b1},  // addu
    '{6'h00, 6'h23, 5'd0, 1'b1, 1'b1},  // subu
    '{6'h00, 6'h24, 5'd0, 1'b1, 1'b1},  // and
    '{6'h00, 6'h25, 5'd0, 1'b1, 1'b1},  // or
    '{6'h00, 6'h2a, 5'd0, 1'b1, 1'b1},  // slt
    '{6'h00, 6'h27, 5'd0, 1'b1, 1'b1},  // nor
    '{6'h00, 6'h04, 5'd0, 1'b1, 1'b1},  // sllv
    '{6'h00, 6'h07, 5'd0, 1'b1, 1'b1},  // srav
    '{6'h00, 6'h00, 5'd0, 1'b0, 1'b1},  // sll
    '{6'h00, 6'h02, 5'd0, 1'b0, 1'b1},  // srl
    '{6'h00, 6'h03, 5'd0, 1'b0, 1'b1},  // sra
    '{6'h00, 6'h18, 5'd0, 1'b1, 1'b1},  // mult
    '{6'h00, 6'h1b, 5'd0, 1'b1, 1'b1},  // divu
    '{6'h00, 6'h11, 5'd0, 1'b1, 1'b0},  // mthi
    '{6'h00, 6'h13, 5'd0, 1'b1, 1'b0},  // mtlo
    '{6'h00, 6'h10, 5'd0, 1'b0, 1'b0},  // mfhi
    '{6'h00, 6'h08, 5'd0, 1'b1, 1'b0},  // jr
    '{6'h00, 6'h09, 5'd0, 1'b1, 1'b0},  // jalr
    '{6'h09, 6'h00, 5'd0, 1'b1, 1'b0},  // addiu
    '{6'h0d, 6'h00, 5'd0, 1'b1, 1'b0},  // ori
    '{6'h0a, 6'h00, 5'd0, 1'b1, 1'b0},  // slti
    '{6'h0f, 6'h00, 5'd0, 1'b0, 1'b0},  // lui
    '{6'h23, 6'h00, 5'd0, 1'b1, 1'b0},  // lw
    '{6'h2b, 6'h00, 5'd0, 1'b1, 1'b1},  // sw
    '{6'h04, 6'h00, 5'd0, 1'b1, 1'b1},  // beq
    '{6'h05, 6'h00, 5'd0, 1'b1, 1'b1},  // bne
    '{6'h07, 6'h00, 5'd0, 1'b1, 1'b0},  // bgtz
    '{6'h01, 6'h00, 5'd0, 1'b1, 1'b0},  // bltz
    '{6'h01, 6'h00, 5'd17, 1'b1, 1'b0}, // bgezal
    '{6'h02, 6'h00, 5'd0, 1'b0, 1'b0}   // j
  };

  ds_bypass_unit #(
    .NUM_FWD (NUM_FWD),
    .FWD_W   (FWD_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_inst        (fs_inst),
    .fs_pc          (fs_pc),
    .ds_allowin     (ds_allowin),
    .es_allowin     (es_allowin),
    .flush          (flush),
    .fwd_bus        (fwd_bus),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_inst        (ds_inst),
    .ds_pc          (ds_pc),
    .rs_value       (rs_value),
    .rt_value       (rt_value),
    .ds_stall       (ds_stall)
`ifdef DS_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fs_to_ds_valid = 1'b0;
    fs_inst        = 32'd0;
    fs_pc          = 32'd0;
    es_allowin     = 1'b1;
    flush          = 1'b0;
    fwd_bus        = '0;
    rf_rdata1      = 32'd0;
    rf_rdata2      = 32'd0;
  endtask

  task automatic set_slot(input int k, input logic v, input logic r,
                          input logic [4:0] a, input logic [31:0] d);
    fwd_bus[k*FWD_W +: FWD_W] = {v, r, a, d};
  endtask

  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_valid = 1'b1;
    fs_inst        = inst;
    fs_pc          = pc;
    step();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset          = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_inst        = 32'h1234_5678;
    fs_pc          = 32'hBFC0_0000;
    step();
    step();
    reset          = 1'b0;
    fs_to_ds_valid = 1'b0;
    #1;
    checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== 3'b010) begin errors++;
      $display("FAIL reset_hs: stall/allowin/to_es got %b want 010", {ds_stall, ds_allowin, ds_to_es_valid}); end
    checks++; if (ds_inst !== 32'd0) begin errors++;
      $display("FAIL reset_inst: got %h want 0", ds_inst); end
    checks++; if (ds_pc !== 32'd0) begin errors++;
      $display("FAIL reset_pc: got %h want 0", ds_pc); end
`ifdef DS_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_forward();
    idle();
    step();
    load(enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'hBFC0_0010);
    set_slot(0, 1'b1, 1'b1, 5'd1, 32'h11);
    set_slot(2, 1'b1, 1'b1, 5'd2, 32'h22);
    rf_rdata1 = 32'hCAFE_0001;
    rf_rdata2 = 32'hCAFE_0002;
    #1;
    checks++; if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin errors++;
      $display("FAIL fwd_raddr: got %0d/%0d want 1/2", rf_raddr1, rf_raddr2); end
    checks++; if (rs_value !== 32'h11) begin errors++;
      $display("FAIL fwd_rs: got %h want 11", rs_value); end
    checks++; if (rt_value !== 32'h22) begin errors++;
      $display("FAIL fwd_rt: got %h want 22", rt_value); end
    checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== 3'b011) begin errors++;
      $display("FAIL fwd_hs: stall/allowin/to_es got %b want 011", {ds_stall, ds_allowin, ds_to_es_valid}); end
    checks++; if (ds_pc !== 32'hBFC0_0010) begin errors++;
      $display("FAIL fwd_pc: got %h want bfc00010", ds_pc); end
    fwd_bus = '0;
    #1;
    checks++; if ({rs_value, rt_value} !== {32'hCAFE_0001, 32'hCAFE_0002}) begin errors++;
      $display("FAIL fwd_rf: got %h/%h want cafe0001/cafe0002", rs_value, rt_value); end
  endtask

  task automatic test_load_use();
    idle();
    step();
    load(enc_i(6'h09, 5'd5, 5'd6, 16'd4), 32'h0000_0100);
    set_slot(0, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
    rf_rdata1 = 32'h55;
    #1;
    checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== 3'b100) begin errors++;
      $display("FAIL lu_stall: stall/allowin/to_es got %b want 100", {ds_stall, ds_allowin, ds_to_es_valid}); end
    fs_to_ds_valid = 1'b1;
    fs_inst        = 32'hFFFF_FFFF;
    fs_pc          = 32'h0000_0104;
    step();
    fs_to_ds_valid = 1'b0;
    fwd_bus        = '0;
    set_slot(1, 1'b1, 1'b1, 5'd5, 32'd7);
    set_slot(2, 1'b1, 1'b0, 5'd6, 32'd0);
    #1;
    checks++; if (ds_inst !== enc_i(6'h09, 5'd5, 5'd6, 16'd4)) begin errors++;
      $display("FAIL lu_hold: got %h want addiu", ds_inst); end
    checks++; if (rs_value !== 32'd7) begin errors++;
      $display("FAIL lu_rs: got %h want 7", rs_value); end
    checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== 3'b011) begin errors++;
      $display("FAIL lu_issue: stall/allowin/to_es got %b want 011", {ds_stall, ds_allowin, ds_to_es_valid}); end
    step();
  endtask

  task automatic test_priority();
    idle();
    step();
    load(enc_r(5'd4, 5'd0, 5'd7, 6'h21), 32'h0000_0200);
    set_slot(0, 1'b1, 1'b1, 5'd4, 32'hA);
    set_slot(1, 1'b1, 1'b1, 5'd4, 32'hB);
    #1;
    checks++; if ({ds_stall, rs_value} !== {1'b0, 32'hA}) begin errors++;
      $display("FAIL prio_both: stall/rs got %b/%h want 0/a", ds_stall, rs_value); end
    set_slot(1, 1'b1, 1'b0, 5'd4, 32'hB);
    #1;
    checks++; if ({ds_stall, rs_value} !== {1'b0, 32'hA}) begin errors++;
      $display("FAIL prio_old_nr: stall/rs got %b/%h want 0/a", ds_stall, rs_value); end
    set_slot(0, 1'b1, 1'b0, 5'd4, 32'hA);
    set_slot(1, 1'b1, 1'b1, 5'd4, 32'hB);
    #1;
    checks++; if (ds_stall !== 1'b1) begin errors++;
      $display("FAIL prio_young_nr: stall got %b want 1", ds_stall); end
    fwd_bus = '0;
    step();
  endtask

  task automatic test_zero();
    idle();
    step();
    load(enc_r(5'd0, 5'd0, 5'd1, 6'h21), 32'h0000_0300);
    set_slot(0, 1'b1, 1'b0, 5'd0, 32'h99);
    #1;
    checks++; if ({ds_stall, rs_value, rt_value} !== {1'b0, 64'd0}) begin errors++;
      $display("FAIL zero_nr: stall/rs/rt got %b/%h/%h want 0/0/0", ds_stall, rs_value, rt_value); end
    set_slot(0, 1'b1, 1'b1, 5'd0, 32'h77);
    #1;
    checks++; if ({rs_value, rt_value} !== 64'd0) begin errors++;
      $display("FAIL zero_rdy: rs/rt got %h/%h want 0/0", rs_value, rt_value); end
    fwd_bus = '0;
    step();
  endtask

  task automatic test_flush_stall();
    idle();
    step();
    load(enc_i(6'h09, 5'd5, 5'd6, 16'd4), 32'h0000_0400);
    set_slot(0, 1'b1, 1'b0, 5'd5, 32'd0);
    #1;
    checks++; if (ds_stall !== 1'b1) begin errors++;
      $display("FAIL fl_pre: stall got %b want 1", ds_stall); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== 3'b010) begin errors++;
      $display("FAIL fl_after: stall/allowin/to_es got %b want 010", {ds_stall, ds_allowin, ds_to_es_valid}); end
    fwd_bus = '0;
    load(enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'h0000_0408);
    #1;
    checks++; if ({ds_inst, ds_to_es_valid} !== {enc_r(5'd1, 5'd2, 5'd3, 6'h21), 1'b1}) begin errors++;
      $display("FAIL fl_refetch: inst/to_es got %h/%b want %h/1", ds_inst, ds_to_es_valid, enc_r(5'd1, 5'd2, 5'd3, 6'h21)); end
    step();
  endtask

  task automatic test_backpressure();
    idle();
    step();
    load(enc_r(5'd1, 5'd2, 5'd3, 6'h25), 32'h0000_0500);
    es_allowin = 1'b0;
    #1;
    checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== 3'b001) begin errors++;
      $display("FAIL bp_hs: stall/allowin/to_es got %b want 001", {ds_stall, ds_allowin, ds_to_es_valid}); end
    fs_to_ds_valid = 1'b1;
    fs_inst        = 32'h0BAD_0BAD;
    fs_pc          = 32'h0000_0504;
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    checks++; if ({ds_inst, ds_pc} !== {enc_r(5'd1, 5'd2, 5'd3, 6'h25), 32'h0000_0500}) begin errors++;
      $display("FAIL bp_hold: inst/pc got %h/%h want held", ds_inst, ds_pc); end
    es_allowin = 1'b1;
    step();
  endtask

`ifdef DS_PERF_CNT_EN
  task automatic test_perf();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    load(enc_i(6'h09, 5'd5, 5'd6, 16'd4), 32'h0000_0600);
    set_slot(0, 1'b1, 1'b0, 5'd5, 32'd0);
    step();
    step();
    step();
    checks++; if (stall_cnt !== 32'd3) begin errors++;
      $display("FAIL perf_cnt: got %0d want 3", stall_cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (stall_cnt !== 32'd0) begin errors++;
      $display("FAIL perf_clr: got %0d want 0", stall_cnt); end
    fwd_bus = '0;
  endtask
`endif

  task automatic test_random();
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_valid;
    bit          m_rs_u;
    bit          m_rt_u;
    int          m_stalls;
    int          kidx;
    logic [4:0]  mrs;
    logic [4:0]  mrt;
    logic [38:0] s;
    bit          rs_f;
    bit          rt_f;
    bit          rs_r;
    bit          rt_r;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    bit          e_stall;
    bit          e_allow;
    bit          e_toes;
    logic [4:0]  r1;
    logic [4:0]  r2;

    idle();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    m_inst   = 32'd0;
    m_pc     = 32'd0;
    m_valid  = 1'b0;
    m_rs_u   = 1'b0;
    m_rt_u   = 1'b1;
    m_stalls = 0;
    for (int n = 0; n < 400; n++) begin
      kidx = int'($urandom_range(0, NK - 1));
      r1   = 5'($urandom_range(0, 7));
      r2   = 5'($urandom_range(0, 7));
      if (kinds[kidx].op == 6'h00)
        fs_inst = {6'h00, r1, r2, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), kinds[kidx].fn};
      else if (kinds[kidx].op == 6'h01)
        fs_inst = {6'h01, r1, kinds[kidx].rtf, 16'($urandom)};
      else
        fs_inst = {kinds[kidx].op, r1, r2, 16'($urandom)};
      fs_pc          = $urandom;
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      es_allowin     = ($urandom_range(0, 4) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NUM_FWD; k++)
        set_slot(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 7)), $urandom);
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      #1;
      // Model: youngest matching producer decides the operand.
      mrs  = m_inst[25:21];
      mrt  = m_inst[20:16];
      rs_f = 0; rt_f = 0; rs_r = 0; rt_r = 0;
      rs_e = rf_rdata1;
      rt_e = rf_rdata2;
      for (int k = 0; k < NUM_FWD; k++) begin
        s = fwd_bus[k*FWD_W +: FWD_W];
        if (!rs_f && m_rs_u && mrs != 0 && s[38] && s[36:32] == mrs) begin
          rs_f = 1; rs_r = s[37]; rs_e = s[31:0];
        end
        if (!rt_f && m_rt_u && mrt != 0 && s[38] && s[36:32] == mrt) begin
          rt_f = 1; rt_r = s[37]; rt_e = s[31:0];
        end
      end
      e_stall = m_valid && ((rs_f && !rs_r) || (rt_f && !rt_r));
      e_allow = !m_valid || (!e_stall && es_allowin);
      e_toes  = m_valid && !e_stall && !flush;
      checks++; if ({ds_stall, ds_allowin, ds_to_es_valid} !== {e_stall, e_allow, e_toes}) begin errors++;
        $display("FAIL rnd_hs[%0d]: stall/allowin/to_es got %b want %b", n,
                 {ds_stall, ds_allowin, ds_to_es_valid}, {e_stall, e_allow, e_toes}); end
      checks++; if ({ds_inst, ds_pc, rf_raddr1, rf_raddr2} !== {m_inst, m_pc, mrs, mrt}) begin errors++;
        $display("FAIL rnd_reg[%0d]: inst/pc got %h/%h want %h/%h", n, ds_inst, ds_pc, m_inst, m_pc); end
      if (!(rs_f && !rs_r)) begin
        checks++; if (rs_value !== rs_e) begin errors++;
          $display("FAIL rnd_rs[%0d]: got %h want %h", n, rs_value, rs_e); end
      end
      if (!(rt_f && !rt_r)) begin
        checks++; if (rt_value !== rt_e) begin errors++;
          $display("FAIL rnd_rt[%0d]: got %h want %h", n, rt_value, rt_e); end
      end
      if (e_stall) m_stalls++;
      if (flush) begin
        m_valid = 1'b0;
      end else if (e_allow) begin
        m_valid = fs_to_ds_valid;
        if (fs_to_ds_valid) begin
          m_inst = fs_inst;
          m_pc   = fs_pc;
          m_rs_u = kinds[kidx].rs_u;
          m_rt_u = kinds[kidx].rt_u;
        end
      end
      step();
    end
`ifdef DS_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'(m_stalls)) begin errors++;
      $display("FAIL rnd_cnt: got %0d want %0d", stall_cnt, m_stalls); end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_priority();
    test_zero();
    test_flush_stall();
    test_backpressure();
`ifdef DS_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ds_bypass_unit.md
Name: ds_bypass_unit

Overview:
Parametrised decode-stage front end for the in-order MIPS pipeline. It holds the fetch-to-decode pipeline register and its valid/allowin handshake, and drives the regfile read addresses. It resolves rs/rt operands from NUM_FWD forwarding buses or the regfile, and raises a stall interlock when a matching producer's data is not yet available (load-use, multi-cycle HI/LO). It generalises the fixed three-stage EXE/MEM/WB bypass to N prioritised producers carrying per-producer data-ready flags, and adds a pipeline flush.

Parameters:
NUM_FWD, 3, number of producer stages; index 0 is youngest (EXE), index NUM_FWD-1 is oldest.
FWD_W, 39, width of one forwarding slot: {valid, ready, addr[4:0], data[31:0]}.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fs_to_ds_valid  in  1  fetch stage holds a valid instruction
fs_inst  in  32  instruction word from fetch
fs_pc  in  32  PC from fetch
ds_allowin  out  1  decode stage accepts a new instruction this cycle
es_allowin  in  1  execute stage accepts
flush  in  1  kill the instruction currently held in decode
fwd_bus  in  NUM_FWD*FWD_W  forwarding slots; slot k occupies bits [k*FWD_W +: FWD_W]
rf_raddr1  out  5  equals rs field
rf_raddr2  out  5  equals rt field
rf_rdata1  in  32  regfile read data for rs
rf_rdata2  in  32  regfile read data for rt
ds_to_es_valid  out  1  decode output is valid and ready to go
ds_inst  out  32  registered instruction
ds_pc  out  32  registered PC
rs_value  out  32  resolved rs operand
rt_value  out  32  resolved rt operand
ds_stall  out  1  interlock active: ds_valid and an unresolved hazard exist
stall_cnt  out  32  stall cycle counter (only when DS_PERF_CNT_EN is defined)

Behaviour:
- Reset: ds_valid=0, ds_inst=0, ds_pc=0, stall_cnt=0. With ds_valid=0, ds_to_es_valid=0, ds_stall=0 and ds_allowin=1.
- Handshake: ds_ready_go = !ds_stall; ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go && !flush.
- Register update: when ds_allowin, ds_valid <= fs_to_ds_valid. When fs_to_ds_valid && ds_allowin, {ds_inst, ds_pc} <= {fs_inst, fs_pc}.
- Flush: the next-cycle ds_valid is 0. Flush has priority over a simultaneous load. A stalled instruction is discarded on flush.
- Source use: rs_used and rt_used are decoded from ds_inst by the sub-module.
  - rs_used: R-type ALU/shift-variable, mult/div, mthi/mtlo, jr/jalr, I-type ALU, lw/sw, all branches.
  - rt_used: R-type ALU, sll/srl/sra, mult/div, beq/bne, sw.
- Match: slot k matches rs when valid_k && rs_used && rs!=0 && addr_k==rs. The rt match is defined the same way with rt_used.
- Resolution: the lowest-index matching slot wins. The operand is data_k if ready_k. With no match, the operand is rf_rdata.
- Interlock: ds_stall = ds_valid && (the winning rs slot is not ready || the winning rt slot is not ready).
  - An older ready slot never overrides a younger not-ready match.
- Register 0 is never forwarded or stalled on; the rf_rdata value for register 0 is used.
- Latency: the decode register adds one cycle. Operand resolution and stall are combinational from ds_inst, fwd_bus and rf_rdata.
- Flush during a stall: the stall is abandoned and the next cycle has ds_valid=0.

Optional Feature:
- DS_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle with ds_stall=1.
  - It saturates at 32'hFFFFFFFF and is cleared by reset only.
- DS_PERF_CNT_EN undefined: the stall_cnt port and its counter are absent.

Decomposition:
- Shared package/header (mycpu.h): opcode/funct constants, FWD_W, and slot field offsets (FWD_VALID=38, FWD_READY=37, FWD_ADDR=36:32, FWD_DATA=31:0).
- One sub-module, ds_src_use_decode: ds_inst -> {rs_used, rt_used}, purely combinational.

Test Plan:
1. addu $3,$1,$2 with slot0={v=1,r=1,addr=1,data=32'h11} and slot2={v=1,r=1,addr=2,data=32'h22} -> rs_value=32'h11, rt_value=32'h22, no stall, ds_to_es_valid=1.
2. Load-use: slot0={v=1,r=0,addr=5} while decoding addiu $6,$5,4 -> ds_stall=1 and ds_allowin=0 for one cycle. The next cycle slot1={v=1,r=1,addr=5,data=7} -> rs_value=7 and the instruction issues.
3. Priority: slot0 and slot1 both target $4 with data 32'hA and 32'hB, both ready -> rs_value=32'hA. With slot0 not ready -> stall, even though slot1 is ready.
4. $0: slot0={v=1,r=0,addr=0} while decoding addu $1,$0,$0 -> no stall, operands equal to rf_rdata (0).
5. Flush during stall: stalled as in test 2, flush=1 -> next cycle ds_valid=0 and ds_to_es_valid=0. A new fetch is accepted the following cycle.
6. Backpressure: es_allowin=0 with a valid, hazard-free instruction -> ds_inst is held and ds_allowin=0. With DS_PERF_CNT_EN, three stall cycles -> stall_cnt=3 and reset clears it.
